// File: rtl/clmul_karatsuba_seq.sv
`default_nettype none
// ============================================================================
// Module   : clmul_karatsuba_seq
// Brief    : Sequential carry-less (GF(2)) W x W multiplier using one
//            Karatsuba level. The three half-width sub-products share a
//            single combinational W/2-bit multiplier and take one cycle each.
//            Define CLMUL_REDUCE_EN to add a bit-serial reduction modulo
//            x^W + POLY after the product is formed.
// Revision : 1.0 - initial release
// ============================================================================
module clmul_karatsuba_seq #(
  parameter int             W    = 16,
  parameter logic [W-1:0]   POLY = 16'h100B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2*W-1:0]   prod
);

  localparam int H = W / 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    P0   = 3'd1,
    P1   = 3'd2,
    P2   = 3'd3,
    RED  = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            accept;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    d0;
  logic [W-1:0]    d1;
  logic [H-1:0]    mul_x;
  logic [H-1:0]    mul_y;
  logic [W-1:0]    mul_p;
  logic [2*W-1:0]  prod_raw;

  // Half-width carry-less multiply; result is W bits with the top bit always 0.
  function automatic logic [W-1:0] clmul_half(input logic [H-1:0] x, input logic [H-1:0] y);
    logic [W-1:0] acc;
    acc = '0;
    for (int k = 0; k < H; k++) begin
      if (y[k]) acc = acc ^ ({{H{1'b0}}, x} << k);
    end
    return acc;
  endfunction

`ifdef CLMUL_REDUCE_EN
  localparam int CW = $clog2(2 * W);
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  red_step;

  // One reduction step: fold bit cnt back into the lower bits via POLY.
  always_comb begin
    red_step = prod;
    if (prod[cnt]) begin
      red_step = prod ^ ({{(2*W-1){1'b0}}, 1'b1} << cnt)
                      ^ ({{W{1'b0}}, POLY} << (cnt - CW'(W)));
    end
  end
`else
  logic unused_poly;
  assign unused_poly = ^POLY;
`endif

  assign accept = in_valid & in_ready;

  // Next-state and handshake outputs.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nx = P0;
      end
      P0: state_nx = P1;
      P1: state_nx = P2;
`ifdef CLMUL_REDUCE_EN
      P2: state_nx = RED;
      RED: if (cnt == CW'(W)) state_nx = OUT;
`else
      P2: state_nx = OUT;
`endif
      OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) state_nx = in_valid ? P0 : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Steer the shared multiplier: lo*lo, (lo^hi)*(lo^hi), hi*hi.
  always_comb begin
    mul_x = a_q[H-1:0];
    mul_y = b_q[H-1:0];
    case (state)
      P1: begin
        mul_x = a_q[H-1:0] ^ a_q[W-1:H];
        mul_y = b_q[H-1:0] ^ b_q[W-1:H];
      end
      P2: begin
        mul_x = a_q[W-1:H];
        mul_y = b_q[W-1:H];
      end
      default: ;
    endcase
  end

  assign mul_p = clmul_half(mul_x, mul_y);

  // Karatsuba recombination; in P2 the multiplier output is d2.
  assign prod_raw = {mul_p, {W{1'b0}}}
                  ^ {{H{1'b0}}, d0 ^ d1 ^ mul_p, {H{1'b0}}}
                  ^ {{W{1'b0}}, d0};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Operand capture, sub-product registers and product register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= '0;
      b_q  <= '0;
      d0   <= '0;
      d1   <= '0;
      prod <= '0;
`ifdef CLMUL_REDUCE_EN
      cnt  <= '0;
`endif
    end else begin
      if (accept) begin
        a_q <= a;
        b_q <= b;
      end
      case (state)
        P0: d0 <= mul_p;
        P1: d1 <= mul_p;
        P2: begin
          prod <= prod_raw;
`ifdef CLMUL_REDUCE_EN
          cnt  <= CW'(2 * W - 2);
`endif
        end
`ifdef CLMUL_REDUCE_EN
        RED: begin
          prod <= red_step;
          if (cnt != CW'(W)) cnt <= cnt - 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clmul_karatsuba_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_clmul_karatsuba_seq
// Brief    : Self-checking bench for clmul_karatsuba_seq (W=16). Expected
//            products come from a shift-and-add GF(2) reference model; with
//            CLMUL_REDUCE_EN the model performs a GF(2^16) multiply instead.
// Revision : 1.0 - initial release
// ============================================================================
module tb_clmul_karatsuba_seq;

  localparam int           W    = 16;
  localparam logic [15:0]  POLY = 16'h100B;
`ifdef CLMUL_REDUCE_EN
  localparam int           LAT  = 3 + (W - 1);
`else
  localparam int           LAT  = 3;
`endif
  localparam int           NSTR = 9;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] prod;

  int n_total = 0;
  int n_pass  = 0;

  clmul_karatsuba_seq #(.W(W), .POLY(POLY)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
  );

  always #5 clk = ~clk;

  // Reference product: plain carry-less multiply, or GF(2^16) multiply.
  function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    logic [15:0] r;
    p = '0;
    r = '0;
`ifdef CLMUL_REDUCE_EN
    for (int i = 15; i >= 0; i--) begin
      r = r[15] ? ((r << 1) ^ POLY) : (r << 1);
      if (y[i]) r = r ^ x;
    end
    p = {16'h0000, r};
`else
    for (int i = 0; i < 16; i++) begin
      if (y[i]) p = p ^ ({16'h0000, x} << i);
    end
`endif
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // One full transaction with out_ready held high; checks latency and result.
  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input string tag);
    int n;
    logic [31:0] e;
    e = ref_mul(x, y);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(LAT));
    check(tag, prod, e);
    @(posedge clk); #1;
    check({tag, "_drop"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] sa [NSTR];
    logic [15:0] sb [NSTR];
    logic [31:0] q [$];
    logic [31:0] e;
    int n, sent, got, cyc, last_out;
    bit acc;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_prod", prod, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Directed corner operands.
    do_op(16'h000B, 16'h0006, "b_x_6");
    do_op(16'hFFFF, 16'hFFFF, "ones");
    do_op(16'h8000, 16'h8000, "msb");
    do_op(16'h0000, 16'h1234, "zero_a");
    do_op(16'hABCD, 16'h0000, "zero_b");

    // Backpressure: result held; new operands during busy/stall are ignored.
    e = ref_mul(16'h0003, 16'h0005);
    a = 16'h0003; b = 16'h0005; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_lat", 32'(n), 32'(LAT));
    for (int i = 0; i < 10; i++) begin
      check("bp_prod", prod, e);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("bp_release_prod", prod, e);
    @(posedge clk); #1;
    check("bp_drop", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("bp_no_ghost", 32'(out_valid), 32'd0);

    // Back-to-back streaming with in_valid and out_ready held high.
    sa[0] = 16'h000B; sb[0] = 16'h0006;
    for (int i = 1; i < NSTR; i++) begin
      sa[i] = 16'($urandom);
      sb[i] = 16'($urandom);
    end
    sent = 0; got = 0; cyc = 0; last_out = -1;
    a = sa[0]; b = sb[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (got < NSTR && cyc < NSTR * (LAT + 1) + 20) begin
      acc = in_valid && in_ready;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("stream_unexpected", prod, 32'hFFFF_FFFF);
        end else begin
          check("stream_prod", prod, q.pop_front());
        end
        if (got == 0) check("stream_first", 32'(cyc), 32'(LAT + 1));
        else          check("stream_gap", 32'(cyc - last_out), 32'(LAT + 1));
        last_out = cyc;
        got++;
      end
      if (acc) begin
        q.push_back(ref_mul(a, b));
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (sent < NSTR) begin
          a = sa[sent]; b = sb[sent];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    check("stream_count", 32'(got), 32'(NSTR));
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset during P1 discards the operation.
    do_op(16'h000B, 16'h0006, "pre_rst");
    a = 16'h1357; b = 16'h2468; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_prod", prod, 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_no_out", 32'(out_valid), 32'd0);
    do_op(16'h1357, 16'h2468, "post_rst");

    // Random single transactions.
    for (int i = 0; i < 150; i++) begin
      do_op(16'($urandom), 16'($urandom), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clmul_karatsuba_seq.md
Name: clmul_karatsuba_seq

Overview:
- Parametrised, multi-cycle carry-less (GF(2)) multiplier for W-bit operands with valid/ready handshakes on input and output.
- Applies one Karatsuba level: three W/2-bit carry-less sub-products are computed sequentially on a single shared combinational half-width multiplier, then XOR-combined into a 2W-bit product.
- Sits beside the combinational GF(2) multiplier leaf cells as the area-optimised, wide-operand option for CRC/GHASH-style datapaths.

Parameters:
- W, 16, operand width; even, >= 4.
- POLY, 16'h100B, low W bits of the reduction polynomial x^W + POLY; used only with CLMUL_REDUCE_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands.
- a  in  W  operand A.
- b  in  W  operand B.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- prod  out  2W  carry-less product; bit 2W-1 is always 0.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset: state=IDLE, out_valid=0, prod=0, internal operand and sub-product registers cleared.
- Notation: lo = bits W/2-1:0, hi = bits W-1:W/2. The half-width multiplier output is W bits wide; its top bit is always 0.
- States: IDLE, P0, P1, P2, [RED], OUT.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a and b, go to P0.
- P0: d0 <= clmul(a.lo, b.lo); go to P1.
- P1: d1 <= clmul(a.lo^a.hi, b.lo^b.hi); go to P2.
- P2: d2 = clmul(a.hi, b.hi).
  - Register prod <= (d2<<W) ^ ((d0^d1^d2)<<(W/2)) ^ d0.
  - Go to OUT, or to RED when reduction is enabled.
- OUT:
  - out_valid=1.
  - prod is held stable while out_ready=0.
  - On out_ready: out_valid drops next cycle; go to IDLE.
  - in_ready = out_ready in OUT. If in_valid and out_ready are both high, the new operands are latched and the next state is P0 (back-to-back, no idle bubble).
- Latency: the operand handshake occurs at edge k; out_valid is high after edge k+3. Sustained throughput is one product per 4 cycles.
- in_valid while busy (P0..RED): ignored. in_ready=0, and a/b may change freely.
- All arithmetic is XOR only; there are no carries. The sub-product widths must never truncate: the full 2W-1 significant bits are preserved.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at their reset values. The in-flight operation is discarded and never emitted.
- a=0 or b=0 gives prod=0 with normal latency; there is no fast path.

Optional Feature:
- Macro: CLMUL_REDUCE_EN.
- Defined:
  - After P2, the FSM enters RED. A counter i runs from 2W-2 down to W, one step per cycle (W-1 cycles).
  - At each step, if prod[i]=1: prod <= prod ^ (1<<i) ^ (POLY<<(i-W)).
  - After the last step: prod[2W-1:W]=0 and prod[W-1:0] = product mod (x^W+POLY); go to OUT.
  - Latency becomes 3+(W-1) cycles.
  - Reset in RED clears the counter.
- Undefined:
  - The RED state, counter and POLY logic are absent.
  - P2 goes directly to OUT, and prod is the raw 2W-bit product.

Test Plan:
1. W=4, no reduction, a=4'hB, b=4'h6, out_ready=1 -> prod=8'h3A, out_valid high exactly 3 cycles after accept.
2. W=16, a=16'hFFFF, b=16'hFFFF -> prod=32'h5555_5555. Then a=16'h8000, b=16'h8000 -> prod=32'h4000_0000. Then a=0, b=16'h1234 -> prod=0.
3. Backpressure, W=16, a=16'h0003, b=16'h0005:
   - Hold out_ready=0 for 10 cycles -> prod=32'h0000_000F stays stable, out_valid stays 1, in_ready stays 0.
   - Pulse in_valid with new operands during the stall -> ignored.
4. Back-to-back: in OUT with out_ready=1 and in_valid=1 (a=4'hB, b=4'h6 again) -> new operands accepted in the same cycle; next out_valid 3 cycles later; no lost or duplicated result. Streaming 8 random pairs -> one product per 4 cycles, all match a bit-serial reference model.
5. Reset: assert rst asynchronously during P1 -> out_valid=0 and prod=0 immediately. After release, in_ready=1 and a fresh operation completes correctly.
6. CLMUL_REDUCE_EN, W=4, POLY=4'h3, a=4'hB, b=4'h6 -> prod=8'h0F, out_valid 6 cycles after accept. With W=16, POLY=16'h100B, 1000 random pairs -> match reference GF(2^16) multiply.
